// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder/subtractor.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of RUN cycles needed to cover the full operand width.
   function automatic int unsigned steps(input int unsigned width, input int unsigned digit);
      return width / digit;
   endfunction

   // Ceiling log2; returns 0 for values of 0 or 1.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      while ((32'd1 << result) < value) begin
         result++;
      end
      return result;
   endfunction

endpackage

// File: rtl/adder_digit.sv
// DIGIT-bit ripple slice of full-adder cells; exposes the carry into the top
// cell so the parent can form signed overflow on the final step.
module adder_digit #(
   parameter int unsigned DIGIT = 1
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             carry_in,
   output logic [DIGIT-1:0] sum,
   output logic             carry_out,
   output logic             carry_into_msb
);

   logic [DIGIT:0] carry;

   // Ripple the carry through DIGIT full-adder cells.
   always_comb begin
      carry    = '0;
      sum      = '0;
      carry[0] = carry_in;
      for (int unsigned i = 0; i < DIGIT; i++) begin
         sum[i]     = a[i] ^ b[i] ^ carry[i];
         carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
   end

   assign carry_out      = carry[DIGIT];
   assign carry_into_msb = carry[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: consumes DIGIT bits per clock through one
// adder_digit slice and reports sum, carry-out and signed overflow with a
// one-cycle done pulse.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned STEPS = steps(WIDTH, DIGIT);
   localparam int unsigned CNT_W = (clog2(STEPS) > 0) ? clog2(STEPS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

   if (WIDTH < 2) begin : g_bad_width
      $error("serial_adder: WIDTH must be at least 2");
   end
   if (DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("serial_adder: DIGIT must be non-zero and divide WIDTH");
   end

   state_t           state;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             carry;
   logic [CNT_W-1:0] cnt;

   logic [DIGIT-1:0] slice_sum;
   logic             slice_cout;
   logic             slice_cmsb;
   logic [WIDTH-1:0] sum_shifted;

   adder_digit #(.DIGIT(DIGIT)) u_digit (
      .a              (op_a[DIGIT-1:0]),
      .b              (op_b[DIGIT-1:0]),
      .carry_in       (carry),
      .sum            (slice_sum),
      .carry_out      (slice_cout),
      .carry_into_msb (slice_cmsb)
   );

   // New slice bits enter at the top while the register shifts right; built
   // with a widened shift so DIGIT == WIDTH needs no zero-width slice.
   always_comb begin
      sum_shifted = (sum >> DIGIT) | (WIDTH'(slice_sum) << (WIDTH - DIGIT));
   end

   // Control FSM with datapath registers and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         op_a  <= '0;
         op_b  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  op_a  <= a;
                  op_b  <= sub ? ~b : b;
                  carry <= sub ? 1'b1 : cin;
                  cnt   <= '0;
                  sum   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            RUN: begin
               op_a  <= op_a >> DIGIT;
               op_b  <= op_b >> DIGIT;
               carry <= slice_cout;
               sum   <= sum_shifted;
               cnt   <= cnt + 1'b1;
               if (cnt == LAST) begin
                  cout  <= slice_cout;
                  ovf   <= slice_cout ^ slice_cmsb;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder over four WIDTH/DIGIT configurations.
module tb_serial_adder;

   localparam int NC = 4;
   localparam int unsigned CFG_W [NC] = '{8, 8, 4, 4};
   localparam int unsigned CFG_D [NC] = '{1, 4, 1, 2};

   typedef struct packed {
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start [NC];
   logic [7:0] a     [NC];
   logic [7:0] b     [NC];
   logic       cin   [NC];
   logic       sub   [NC];

   exp_t q [NC][$];
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
      end
   endtask

   // Reference: plain integer add; overflow from operand/result sign bits.
   function automatic exp_t model(input int unsigned w, input logic [7:0] av, input logic [7:0] bv,
                                  input logic c, input logic s);
      int unsigned mask, x, y, t;
      exp_t e;
      mask   = (32'd1 << w) - 32'd1;
      x      = {24'd0, av} & mask;
      y      = (s ? ~{24'd0, bv} : {24'd0, bv}) & mask;
      t      = x + y + (s ? 32'd1 : {31'd0, c});
      e.sum  = 8'(t & mask);
      e.cout = t[w];
      e.ovf  = (x[w-1] == y[w-1]) && (t[w-1] != x[w-1]);
      return e;
   endfunction

   for (genvar g = 0; g < NC; g++) begin : cfg
      localparam int unsigned W = CFG_W[g];
      localparam int unsigned S = CFG_W[g] / CFG_D[g];

      logic         busy, done, cout, ovf;
      logic [W-1:0] sum;
      int unsigned  m_state;   // 0 idle, 1 run, 2 done
      int unsigned  m_cnt;

      serial_adder #(.WIDTH(W), .DIGIT(CFG_D[g])) dut (
         .clk   (clk),
         .rst_n (rst_n),
         .start (start[g]),
         .a     (a[g][W-1:0]),
         .b     (b[g][W-1:0]),
         .cin   (cin[g]),
         .sub   (sub[g]),
         .busy  (busy),
         .done  (done),
         .sum   (sum),
         .cout  (cout),
         .ovf   (ovf)
      );

      // Bench-side protocol model; pushes the expected result on acceptance.
      always @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            m_state <= 0;
            m_cnt   <= 0;
            q[g].delete();
         end else if (m_state == 1) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == S - 1) m_state <= 2;
         end else if (start[g]) begin
            q[g].push_back(model(W, a[g], b[g], cin[g], sub[g]));
            m_state <= 1;
            m_cnt   <= 0;
         end else begin
            m_state <= 0;
         end
      end

      // Compare status every cycle and the result when the model expects done.
      always @(negedge clk) begin
         exp_t e;
         if (rst_n) begin
            check($sformatf("cfg%0d busy", g), 32'(busy), 32'(m_state == 1));
            check($sformatf("cfg%0d done", g), 32'(done), 32'(m_state == 2));
            if (m_state == 2 && q[g].size() != 0) begin
               e = q[g].pop_front();
               check($sformatf("cfg%0d sum", g), 32'(sum), 32'(e.sum));
               check($sformatf("cfg%0d cout", g), 32'(cout), 32'(e.cout));
               check($sformatf("cfg%0d ovf", g), 32'(ovf), 32'(e.ovf));
            end
         end
      end
   end

   // Drive one operation from a falling edge; returns at the falling edge
   // where done is expected high.
   task automatic op(input int g, input logic [7:0] av, input logic [7:0] bv,
                     input logic c, input logic s);
      int unsigned n;
      n        = CFG_W[g] / CFG_D[g];
      start[g] = 1'b1;
      a[g]     = av;
      b[g]     = bv;
      cin[g]   = c;
      sub[g]   = s;
      @(negedge clk);
      start[g] = 1'b0;
      a[g]     = 8'($urandom);
      b[g]     = 8'($urandom);
      cin[g]   = 1'($urandom);
      sub[g]   = 1'($urandom);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b1;
      for (int i = 0; i < NC; i++) begin
         start[i] = 1'b0;
         a[i]     = 8'h00;
         b[i]     = 8'h00;
         cin[i]   = 1'b0;
         sub[i]   = 1'b0;
      end
      #2 rst_n = 1'b0;
      #1;
      check("reset sum8", 32'(cfg[0].sum), 32'h0);
      check("reset busy8", 32'(cfg[0].busy), 32'h0);
      check("reset done8", 32'(cfg[0].done), 32'h0);
      check("reset cout8", 32'(cfg[0].cout), 32'h0);
      check("reset ovf8", 32'(cfg[0].ovf), 32'h0);
      check("reset sum4", 32'(cfg[2].sum), 32'h0);
      #9 rst_n = 1'b1;
      @(negedge clk);

      // Full carry ripple on the bit-serial configuration.
      op(0, 8'hFF, 8'h01, 1'b0, 1'b0);
      check("t1 sum", 32'(cfg[0].sum), 32'h00);
      check("t1 cout", 32'(cfg[0].cout), 32'h1);
      check("t1 ovf", 32'(cfg[0].ovf), 32'h0);

      // Nibble-serial: positive overflow, then a subtraction with borrow.
      op(1, 8'h7F, 8'h01, 1'b0, 1'b0);
      check("t2a sum", 32'(cfg[1].sum), 32'h80);
      check("t2a cout", 32'(cfg[1].cout), 32'h0);
      check("t2a ovf", 32'(cfg[1].ovf), 32'h1);
      op(1, 8'h05, 8'h07, 1'b0, 1'b1);
      check("t2b sum", 32'(cfg[1].sum), 32'hFE);
      check("t2b cout", 32'(cfg[1].cout), 32'h0);
      check("t2b ovf", 32'(cfg[1].ovf), 32'h0);

      // Exhaustive 4-bit sweeps, issued back-to-back from the DONE cycle.
      fork
         for (int v = 0; v < 1024; v++) op(2, 8'(v & 15), 8'((v >> 4) & 15), v[8], v[9]);
         for (int v = 0; v < 1024; v++) op(3, 8'(v & 15), 8'((v >> 4) & 15), v[8], v[9]);
      join

      // start held high with operands changing every cycle.
      start[0] = 1'b1;
      repeat (40) begin
         a[0]   = 8'($urandom);
         b[0]   = 8'($urandom);
         cin[0] = 1'($urandom);
         sub[0] = 1'($urandom);
         @(negedge clk);
      end
      start[0] = 1'b0;
      repeat (10) @(negedge clk);

      // A start pulse mid-RUN must not disturb the operation in flight.
      start[0] = 1'b1;
      a[0] = 8'h3C; b[0] = 8'h5A; cin[0] = 1'b1; sub[0] = 1'b0;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (2) @(negedge clk);
      start[0] = 1'b1;
      a[0] = 8'h11; b[0] = 8'h22; cin[0] = 1'b0; sub[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (5) @(negedge clk);
      check("t5 sum", 32'(cfg[0].sum), 32'h97);
      check("t5 cout", 32'(cfg[0].cout), 32'h0);
      check("t5 ovf", 32'(cfg[0].ovf), 32'h1);

      // Asynchronous reset during RUN step 3, after a result with cout=1.
      op(0, 8'hFF, 8'h01, 1'b0, 1'b0);
      start[0] = 1'b1;
      a[0] = 8'h0F; b[0] = 8'h03; cin[0] = 1'b0; sub[0] = 1'b0;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t6 sum", 32'(cfg[0].sum), 32'h0);
      check("t6 busy", 32'(cfg[0].busy), 32'h0);
      check("t6 done", 32'(cfg[0].done), 32'h0);
      check("t6 cout", 32'(cfg[0].cout), 32'h0);
      check("t6 ovf", 32'(cfg[0].ovf), 32'h0);
      #4 rst_n = 1'b1;
      @(negedge clk);
      op(0, 8'h0F, 8'h03, 1'b1, 1'b0);
      check("t6 post sum", 32'(cfg[0].sum), 32'h13);
      check("t6 post cout", 32'(cfg[0].cout), 32'h0);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
